hazard_ctrl: RTL and testbench



---
 rtl/hazard_pkg.sv | 48 ++++
 rtl/hazard_fwd_sel.sv | 39 +++
 rtl/hazard_ctrl.sv | 162 ++++++++++++++++
 tb/tb_hazard_ctrl.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : hazard_pkg
//  Brief   : Shared types and constants for the pipeline hazard controller:
//            shadow-pipeline entry, controller state encoding and forwarding
//            source select constants.
//  Rev     : 1.0  initial release
// ============================================================================
package hazard_pkg;

  // Register addresses are carried zero-extended to this width inside the
  // shadow pipeline so the entry type stays fixed for any REG_ADDR_W up to it.
  localparam int HZ_ADDR_MAX_W = 8;

  typedef logic [HZ_ADDR_MAX_W-1:0] hz_addr_t;

  // One in-flight instruction as seen by the hazard logic.
  typedef struct packed {
    logic     valid;
    hz_addr_t rd;
    logic     reg_write;
    logic     mem_read;
    hz_addr_t rs;
    hz_addr_t rt;
    logic     use_rs;
    logic     use_rt;
  } hz_entry_t;

  localparam hz_entry_t HZ_ENTRY_NULL = '0;

  // Controller state encoding.
  typedef enum logic [1:0] {
    HZ_ST_RUN     = 2'd0,
    HZ_ST_LDSTALL = 2'd1,
    HZ_ST_FLUSH   = 2'd2
  } hz_state_t;

  // Forwarding source select: 0 = register file, k = shadow stage k.
  localparam int FWD_SRC_RF        = 0;
  localparam int FWD_SRC_STAGE_MAX = 4;

  // True when the entry will write a real (non-r0) destination register.
  function automatic logic hz_writes_reg(input hz_entry_t e);
    return e.valid && e.reg_write && (e.rd != '0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_fwd_sel.sv
`default_nettype none
// ============================================================================
//  Module  : hazard_fwd_sel
//  Brief   : Priority forwarding select for one EXE operand. Returns the
//            nearest older stage that writes the operand's source register,
//            or the register-file select when none does.
//  Rev     : 1.0  initial release
// ============================================================================
module hazard_fwd_sel
  import hazard_pkg::*;
#(
  parameter int FWD_DEPTH = 2,
  parameter int SEL_W     = $clog2(FWD_DEPTH + 1)
) (
  input  hz_addr_t                i_src,
  input  logic                    i_use_src,
  input  hz_entry_t [FWD_DEPTH:1] i_older,
  output logic      [SEL_W-1:0]   o_sel
);

  // Only rd/valid/reg_write of the older entries matter here; the remaining
  // fields ride along because the whole entry is passed through.
  logic w_unused_fields;
  assign w_unused_fields = ^i_older;

  // Scan from the oldest stage to the youngest so the nearest match wins.
  always_comb begin
    o_sel = SEL_W'(FWD_SRC_RF);
    if (i_use_src && (i_src != '0)) begin
      for (int k = FWD_DEPTH; k >= 1; k--) begin
        if (hz_writes_reg(i_older[k]) && (i_older[k].rd == i_src)) begin
          o_sel = SEL_W'(k);
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module  : hazard_ctrl
//  Brief   : Pipeline hazard controller. Tracks in-flight instructions in a
//            shadow pipeline, detects load-use hazards (stall + bubble),
//            selects EXE forwarding sources and flushes on taken branches.
//            Saturating stall/flush event counters.
//  Rev     : 1.0  initial release
// ============================================================================
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W  = 5,
  parameter int FWD_DEPTH   = 2,
  parameter int LOAD_LAT    = 1,
  parameter int FLUSH_DEPTH = 3,
  parameter int CNT_W       = 32
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             enable,
  input  logic [REG_ADDR_W-1:0]            id_rs,
  input  logic [REG_ADDR_W-1:0]            id_rt,
  input  logic                             id_use_rs,
  input  logic                             id_use_rt,
  input  logic [REG_ADDR_W-1:0]            id_rd,
  input  logic                             id_reg_write,
  input  logic                             id_mem_read,
  input  logic                             br_taken,
  output logic                             stall,
  output logic                             bubble,
  output logic [FLUSH_DEPTH-1:0]           flush,
  output logic [$clog2(FWD_DEPTH+1)-1:0]   fwd_a,
  output logic [$clog2(FWD_DEPTH+1)-1:0]   fwd_b,
  output logic [CNT_W-1:0]                 stall_cnt,
  output logic [CNT_W-1:0]                 flush_cnt
);

  localparam int SEL_W = $clog2(FWD_DEPTH + 1);

  // Entry 0 = EXE, entry k = k stages after EXE.
  hz_entry_t [FWD_DEPTH:0] entries_q, entries_d;
  hz_state_t               state_q, state_d;
  logic      [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic      [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;

  hz_entry_t               w_id_entry;
  logic                    w_load_hit;

  // Package the ID-stage instruction as a shadow entry (addresses zero-extended).
  always_comb begin
    w_id_entry                        = HZ_ENTRY_NULL;
    w_id_entry.valid                  = 1'b1;
    w_id_entry.rd[REG_ADDR_W-1:0]     = id_rd;
    w_id_entry.reg_write              = id_reg_write;
    w_id_entry.mem_read               = id_mem_read;
    w_id_entry.rs[REG_ADDR_W-1:0]     = id_rs;
    w_id_entry.rt[REG_ADDR_W-1:0]     = id_rt;
    w_id_entry.use_rs                 = id_use_rs;
    w_id_entry.use_rt                 = id_use_rt;
  end

  // Load-use: an ID source depends on a load whose data is not yet forwardable.
  always_comb begin
    w_load_hit = 1'b0;
    for (int j = 0; j < LOAD_LAT; j++) begin
      if (hz_writes_reg(entries_q[j]) && entries_q[j].mem_read) begin
        if (id_use_rs && (entries_q[j].rd == w_id_entry.rs)) w_load_hit = 1'b1;
        if (id_use_rt && (entries_q[j].rd == w_id_entry.rt)) w_load_hit = 1'b1;
      end
    end
  end

  // Controller next state and stall/bubble/flush outputs; a taken branch
  // beats a load-use stall, and a frozen pipeline asserts nothing.
  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    bubble  = 1'b0;
    flush   = '0;
    if (enable) begin
      case (state_q)
        HZ_ST_RUN:     if (w_load_hit)  state_d = HZ_ST_LDSTALL;
        HZ_ST_LDSTALL: if (!w_load_hit) state_d = HZ_ST_RUN;
        HZ_ST_FLUSH:                    state_d = HZ_ST_RUN;
        default:                        state_d = HZ_ST_RUN;
      endcase
      if (br_taken) begin
        state_d = HZ_ST_FLUSH;
        flush   = '1;
      end else if (w_load_hit) begin
        stall  = 1'b1;
        bubble = 1'b1;
      end
    end
  end

  // Shadow pipeline advance: shift, insert ID (or a bubble), then kill the
  // entries that correspond to flushed pipeline registers.
  always_comb begin
    entries_d = entries_q;
    if (enable) begin
      for (int k = 1; k <= FWD_DEPTH; k++) begin
        entries_d[k] = entries_q[k-1];
      end
      entries_d[0] = bubble ? HZ_ENTRY_NULL : w_id_entry;
      if (br_taken) begin
        for (int k = 0; k < FLUSH_DEPTH - 1; k++) begin
          entries_d[k] = HZ_ENTRY_NULL;
        end
      end
    end
  end

  // Saturating event counters (stall and flush are already enable-gated).
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if ((flush != '0) && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      entries_q   <= '0;
      state_q     <= HZ_ST_RUN;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      entries_q   <= entries_d;
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

  hazard_fwd_sel #(
    .FWD_DEPTH (FWD_DEPTH),
    .SEL_W     (SEL_W)
  ) u_fwd_a (
    .i_src     (entries_q[0].rs),
    .i_use_src (entries_q[0].use_rs),
    .i_older   (entries_q[FWD_DEPTH:1]),
    .o_sel     (fwd_a)
  );

  hazard_fwd_sel #(
    .FWD_DEPTH (FWD_DEPTH),
    .SEL_W     (SEL_W)
  ) u_fwd_b (
    .i_src     (entries_q[0].rt),
    .i_use_src (entries_q[0].use_rt),
    .i_older   (entries_q[FWD_DEPTH:1]),
    .o_sel     (fwd_b)
  );

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module  : tb_hazard_ctrl
//  Brief   : Self-checking bench for hazard_ctrl: directed vector table for
//            the named scenarios, then random traffic against a queue model.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_hazard_ctrl;

  localparam int REG_ADDR_W  = 5;
  localparam int FWD_DEPTH   = 2;
  localparam int LOAD_LAT    = 1;
  localparam int FLUSH_DEPTH = 3;
  localparam int CNT_W       = 32;

  logic                  clk = 1'b0;
  logic                  rst, enable, br_taken;
  logic [REG_ADDR_W-1:0] id_rs, id_rt, id_rd;
  logic                  id_use_rs, id_use_rt, id_reg_write, id_mem_read;
  logic                  stall, bubble;
  logic [FLUSH_DEPTH-1:0] flush;
  logic [1:0]            fwd_a, fwd_b;
  logic [CNT_W-1:0]      stall_cnt, flush_cnt;

  always #5 clk = ~clk;

  hazard_ctrl #(
    .REG_ADDR_W  (REG_ADDR_W),
    .FWD_DEPTH   (FWD_DEPTH),
    .LOAD_LAT    (LOAD_LAT),
    .FLUSH_DEPTH (FLUSH_DEPTH),
    .CNT_W       (CNT_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_use_rs    (id_use_rs),
    .id_use_rt    (id_use_rt),
    .id_rd        (id_rd),
    .id_reg_write (id_reg_write),
    .id_mem_read  (id_mem_read),
    .br_taken     (br_taken),
    .stall        (stall),
    .bubble       (bubble),
    .flush        (flush),
    .fwd_a        (fwd_a),
    .fwd_b        (fwd_b),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
  );

  // One cycle of stimulus plus the outputs expected during that cycle.
  typedef struct {
    bit rst, en, br;
    int rs, rt;
    bit urs, urt;
    int rd;
    bit rw, mr;
    bit st;
    int fl, fa, fb, sc, fc;
  } vec_t;

  // Model view of one instruction in flight.
  typedef struct {
    bit v;
    int rd;
    bit rw, mr;
    int rs, rt;
    bit urs, urt;
  } m_inst_t;

  int      total = 0;
  int      bad   = 0;
  vec_t    tbl[21];
  m_inst_t mq[$];         // index 0 = EXE, older instructions further back
  m_inst_t m_null;
  logic [CNT_W-1:0] m_sc, m_fc;

  function automatic vec_t v(bit rst_i, bit en_i, bit br_i, int rs_i, int rt_i,
                             bit urs_i, bit urt_i, int rd_i, bit rw_i, bit mr_i,
                             bit st_i, int fl_i, int fa_i, int fb_i, int sc_i, int fc_i);
    vec_t t;
    t.rst = rst_i; t.en = en_i; t.br = br_i; t.rs = rs_i; t.rt = rt_i;
    t.urs = urs_i; t.urt = urt_i; t.rd = rd_i; t.rw = rw_i; t.mr = mr_i;
    t.st = st_i; t.fl = fl_i; t.fa = fa_i; t.fb = fb_i; t.sc = sc_i; t.fc = fc_i;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t t);
    rst          = t.rst;
    enable       = t.en;
    br_taken     = t.br;
    id_rs        = REG_ADDR_W'(t.rs);
    id_rt        = REG_ADDR_W'(t.rt);
    id_use_rs    = t.urs;
    id_use_rt    = t.urt;
    id_rd        = REG_ADDR_W'(t.rd);
    id_reg_write = t.rw;
    id_mem_read  = t.mr;
  endtask

  task automatic chk_all(input string tag, input bit st, input int fl, input int fa,
                         input int fb, input logic [CNT_W-1:0] sc, input logic [CNT_W-1:0] fc);
    chk({tag, ".stall"},     64'(stall),     64'(st));
    chk({tag, ".bubble"},    64'(bubble),    64'(st));
    chk({tag, ".flush"},     64'(flush),     64'(fl));
    chk({tag, ".fwd_a"},     64'(fwd_a),     64'(fa));
    chk({tag, ".fwd_b"},     64'(fwd_b),     64'(fb));
    chk({tag, ".stall_cnt"}, 64'(stall_cnt), 64'(sc));
    chk({tag, ".flush_cnt"}, 64'(flush_cnt), 64'(fc));
  endtask

  // ---------------- reference model ----------------
  function automatic m_inst_t m_from_vec(vec_t t);
    m_inst_t i;
    i.v = 1'b1; i.rd = t.rd; i.rw = t.rw; i.mr = t.mr;
    i.rs = t.rs; i.rt = t.rt; i.urs = t.urs; i.urt = t.urt;
    return i;
  endfunction

  // An ID source needs a load result that is still fewer than LOAD_LAT stages past EXE.
  function automatic bit m_hit(m_inst_t id);
    for (int j = 0; j < LOAD_LAT; j++) begin
      if (mq[j].v && mq[j].rw && mq[j].mr && mq[j].rd != 0 &&
          ((id.urs && id.rs == mq[j].rd) || (id.urt && id.rt == mq[j].rd)))
        return 1'b1;
    end
    return 1'b0;
  endfunction

  // Nearest older producer of the register, or 0 for the register file.
  function automatic int m_fwd(int src, bit use_src);
    if (!use_src || src == 0) return 0;
    for (int k = 1; k <= FWD_DEPTH; k++) begin
      if (mq[k].v && mq[k].rw && mq[k].rd == src) return k;
    end
    return 0;
  endfunction

  task automatic m_reset();
    mq.delete();
    repeat (FWD_DEPTH + 1) mq.push_back(m_null);
    m_sc = '0;
    m_fc = '0;
  endtask

  task automatic m_step(input vec_t t);
    bit hit, st;
    if (t.rst) begin
      m_reset();
    end else if (t.en) begin
      hit = m_hit(m_from_vec(t));
      st  = hit && !t.br;
      if (st && m_sc != '1) m_sc++;
      if (t.br && m_fc != '1) m_fc++;
      mq.push_front(st ? m_null : m_from_vec(t));
      void'(mq.pop_back());
      if (t.br) begin
        for (int k = 0; k < FLUSH_DEPTH - 1; k++) mq[k] = m_null;
      end
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    vec_t t;
    vec_t rst_row;

    m_null = '{default: 0};
    rst_row = v(1,1,0, 0,0,0,0, 0,0,0, 0,0,0,0,0,0);
    drive(rst_row);
    repeat (2) @(posedge clk);
    #1;

    //             rst en br  rs rt urs urt  rd rw mr  st fl fa fb sc fc
    tbl[0]  = v(1,1,0, 0,0,0,0,  0,0,0,  0,0,0,0,0,0);  // reset state
    tbl[1]  = v(0,1,0, 1,2,1,1,  3,1,0,  0,0,0,0,0,0);  // add r3
    tbl[2]  = v(0,1,0, 3,5,1,1,  6,1,0,  0,0,0,0,0,0);  // reads r3 / r5
    tbl[3]  = v(0,1,0, 0,0,0,0,  7,1,0,  0,0,1,0,0,0);  // fwd_a=1 from stage 1
    tbl[4]  = v(0,1,0, 0,0,0,0,  7,1,0,  0,0,0,0,0,0);  // second writer of r7
    tbl[5]  = v(0,1,0, 1,7,1,1,  8,1,0,  0,0,0,0,0,0);  // reads r7 on rt
    tbl[6]  = v(0,1,0, 0,0,0,0,  0,1,1,  0,0,0,1,0,0);  // nearest r7 wins; lw r0
    tbl[7]  = v(0,1,0, 0,0,1,1,  9,1,0,  0,0,0,0,0,0);  // reads r0 after lw r0: no stall
    tbl[8]  = v(0,1,0, 0,0,0,0,  4,1,1,  0,0,0,0,0,0);  // r0 never forwarded; lw r4
    tbl[9]  = v(0,1,0, 4,2,1,0, 10,1,0,  1,0,0,0,0,0);  // load-use on r4
    tbl[10] = v(0,1,0, 4,2,1,0, 10,1,0,  0,0,0,0,1,0);  // stall lasts one cycle
    tbl[11] = v(0,1,0, 0,0,0,0,  0,0,0,  0,0,2,0,1,0);  // fwd_a=2 from load
    tbl[12] = v(0,1,0, 0,0,0,0,  5,1,1,  0,0,0,0,1,0);  // lw r5
    tbl[13] = v(0,1,1, 0,5,0,1, 11,1,0,  0,7,0,0,1,0);  // branch beats load-use
    tbl[14] = v(0,1,0, 0,0,0,0,  0,0,0,  0,0,0,0,1,1);  // flush counted, no stall counted
    tbl[15] = v(0,1,0, 0,0,0,0,  6,1,1,  0,0,0,0,1,1);  // lw r6
    tbl[16] = v(0,1,0, 6,0,1,0, 12,1,0,  1,0,0,0,1,1);  // load-use on r6
    tbl[17] = v(1,1,1, 6,0,1,0, 12,1,0,  0,7,0,0,2,1);  // reset in LDSTALL with branch
    tbl[18] = v(0,1,0, 6,0,1,0, 12,1,0,  0,0,0,0,0,0);  // everything cleared
    tbl[19] = v(0,0,1, 0,0,0,0,  1,1,1,  0,0,0,0,0,0);  // frozen: no flush, lw r1 dropped
    tbl[20] = v(0,1,0, 1,0,1,0, 13,1,0,  0,0,0,0,0,0);  // no stall: lw r1 never entered

    for (int i = 0; i < 21; i++) begin
      drive(tbl[i]);
      @(negedge clk);
      chk_all($sformatf("vec%0d", i), tbl[i].st, tbl[i].fl, tbl[i].fa, tbl[i].fb,
              CNT_W'(tbl[i].sc), CNT_W'(tbl[i].fc));
      @(posedge clk);
      #1;
    end

    // Random traffic: resynchronise model and DUT with a reset, then compare.
    drive(rst_row);
    @(posedge clk);
    #1;
    m_reset();
    for (int n = 0; n < 3000; n++) begin
      t     = v(0,1,0, 0,0,0,0, 0,0,0, 0,0,0,0,0,0);
      t.rst = ($urandom_range(0, 63) == 0);
      t.en  = ($urandom_range(0, 9) != 0);
      t.br  = ($urandom_range(0, 11) == 0);
      t.rs  = $urandom_range(0, 3);
      t.rt  = $urandom_range(0, 3);
      t.urs = $urandom_range(0, 1);
      t.urt = $urandom_range(0, 1);
      t.rd  = $urandom_range(0, 3);
      t.rw  = ($urandom_range(0, 3) != 0);
      t.mr  = ($urandom_range(0, 2) == 0);
      drive(t);
      @(negedge clk);
      chk_all("rand",
              t.en && m_hit(m_from_vec(t)) && !t.br,
              (t.en && t.br) ? 7 : 0,
              m_fwd(mq[0].rs, mq[0].urs),
              m_fwd(mq[0].rt, mq[0].urt),
              m_sc, m_fc);
      @(posedge clk);
      m_step(t);
      #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
